imm_encoder: RTL and testbench
==============================

# imm_encoder

Pipelined RISC-V instruction encoder: packs a 32-bit immediate plus register/function fields into an instruction word, the inverse of the core's immediate extender. It feeds the test-program generator and boot-ROM builder, sitting between the stimulus source and instruction memory. A valid/ready handshake supports backpressure. For every in-range immediate, the produced word decodes back to the same immediate through the extender.

## Interface
- No parameters; widths fixed by RV32I.
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  encoder accepts request this cycle
- in_immsrc  in  3  000 I, 001 S, 010 B, 011 J, 100 U; 101–111 illegal
- in_imm  in  32  immediate as a full signed byte value (B/J are offsets)
- in_opcode  in  7  instr[6:0]
- in_rd, in_rs1, in_rs2  in  5 each  register fields
- in_funct3  in  3  instr[14:12]
- out_valid  out  1  encoded word valid
- out_ready  in  1  consumer accepts word
- out_instr  out  32  encoded instruction
- out_err  out  1  immediate out of range or immsrc illegal (qualified by out_valid)
- err_count  out  8  saturating count of errored words delivered

## Operation
- Stage 1 (S1) registers the request and computes range flags. Stage 2 (S2) assembles out_instr and out_err.
- Field placement:
  - I: [31:20]=imm[11:0], [19:15]=rs1, [14:12]=funct3, [11:7]=rd, [6:0]=opcode.
  - S: [31:25]=imm[11:5], [24:20]=rs2, rs1, funct3, [11:7]=imm[4:0], opcode.
  - B: [31]=imm[12], [30:25]=imm[10:5], rs2, rs1, funct3, [11:8]=imm[4:1], [7]=imm[11], opcode.
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12], rd, opcode.
  - U: [31:12]=imm[31:12], rd, opcode.
  - Unused fields are not placed: rs2 for I/J/U; rd for S/B; funct3 for J/U.
- Range rules: I/S need imm[31:11] all equal. B needs imm[31:12] all equal and imm[0]=0. J needs imm[31:20] all equal and imm[0]=0. U needs imm[11:0]=0.
- Out-of-range immediates are still encoded with truncated bits and out_err=1.
- Illegal immsrc gives out_instr=0 and out_err=1.
- err_count increments on out_valid & out_ready & out_err and saturates at 255.

## Timing
- Reset values: out_valid=0, out_instr=0, out_err=0, err_count=0, both stages empty. in_ready=1 in the first cycle after reset.
- Latency: 2 cycles from input handshake to out_valid with an idle consumer.
- Throughput: 1 word per cycle.
- Advance rules:
  - S2 loads when !out_valid | out_ready.
  - S1 loads when !s1_valid | S2 loads.
  - in_ready = !s1_valid | S2 loads (combinational).
- out_instr and out_err hold stable while out_valid & !out_ready.
- Simultaneous input and output handshakes with both stages full: both stages shift and no data is lost.
- reset mid-operation flushes in-flight words. No partial output, err_count cleared.
- in_valid with in_ready=0: the request is not captured; the producer must hold it.

## Configuration
- IMM_RANGE_CHECK_EN defined: range rules, out_err and err_count as above.
- Undefined: no checks. out_err is tied 0 and err_count is tied 0. Illegal immsrc still encodes 0. Immediates are silently truncated.

## Structure
- Shared package riscv_imm_pkg holds:
  - immsrc constants IMM_I, IMM_S, IMM_B, IMM_J, IMM_U.
  - Opcode constants OP_IMM, OP_STORE, OP_BRANCH, OP_JAL, OP_LUI.
- One sub-module, imm_range_check: combinational, (immsrc, imm) -> err. Instantiated in S1 only under IMM_RANGE_CHECK_EN.

## Test plan
- I, imm=-1, rs1=2, funct3=0, rd=1, opcode=0010011 -> out_instr=32'hFFF10093, out_err=0, two cycles after accept.
- S, imm=8, rs2=5, rs1=2, funct3=010, opcode=0100011 -> 32'h00512423. B, imm=-4, rs1=rs2=0, funct3=0, opcode=1100011 -> 32'hFE000EE3.
- J, imm=2048, rd=1, opcode=1101111 -> 32'h001000EF. J, imm=3 -> out_err=1, err_count becomes 1.
- Backpressure: 4 back-to-back requests with out_ready low for 3 cycles -> in_ready drops after 2 accepts, all 4 words delivered in order, none duplicated.
- 260 errored words (I, imm=4096) -> err_count saturates at 255. Assert reset mid-stream -> out_valid=0 and err_count=0 next cycle.
- Random round-trip: 10k in-range requests -> extender(out_instr[31:7], immsrc) equals in_imm for I/S/B/J, and out_instr[31:12]==in_imm[31:12] for U.

Source files
------------

// File: rtl/riscv_imm_pkg.sv
// rtl/riscv_imm_pkg.sv - immsrc/opcode constants and the RV32 immediate field packer
//
// Shared by imm_encoder and imm_range_check.
//   IMM_I/S/B/J/U : 3-bit immediate-format selectors (101-111 are illegal)
//   OP_*          : base opcodes for the formats the generator emits most
//   encode_instr  : places imm and register/function fields into a 32-bit word;
//                   illegal formats encode to all zeros
package riscv_imm_pkg;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // Out-of-range immediates are simply truncated here; flagging them is the
    // range checker's job.
    function automatic logic [31:0] encode_instr(
        input logic [2:0]  immsrc,
        input logic [31:0] imm,
        input logic [6:0]  opcode,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [2:0]  funct3
    );
        logic [31:0] w;
        case (immsrc)
            IMM_I:   w = {imm[11:0], rs1, funct3, rd, opcode};
            IMM_S:   w = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            IMM_B:   w = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            IMM_J:   w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            IMM_U:   w = {imm[31:12], rd, opcode};
            default: w = 32'h0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/imm_range_check.sv
// rtl/imm_range_check.sv - combinational range/legality check of an immediate for its format
//
// Ports:
//   immsrc in  3   immediate format selector
//   imm    in  32  immediate as a signed byte value
//   err    out 1   immediate not representable in the format, or immsrc illegal
module imm_range_check
    import riscv_imm_pkg::*;
(
    input  logic [2:0]  immsrc,
    input  logic [31:0] imm,
    output logic        err
);

    // A field of N significant bits is representable when every bit above it
    // matches the sign bit, i.e. the upper slice is all-ones or all-zeros.
    logic upper_is_sext_11;
    logic upper_is_sext_12;
    logic upper_is_sext_20;

    assign upper_is_sext_11 = (&imm[31:11]) | ~(|imm[31:11]);
    assign upper_is_sext_12 = (&imm[31:12]) | ~(|imm[31:12]);
    assign upper_is_sext_20 = (&imm[31:20]) | ~(|imm[31:20]);

    always_comb begin
        err = 1'b1;
        case (immsrc)
            IMM_I, IMM_S: err = !upper_is_sext_11;
            // Branch/jump offsets are halfword aligned; bit 0 is never encoded.
            IMM_B:        err = !upper_is_sext_12 || imm[0];
            IMM_J:        err = !upper_is_sext_20 || imm[0];
            IMM_U:        err = |imm[11:0];
            default:      err = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// rtl/imm_encoder.sv - two-stage valid/ready RISC-V instruction encoder
//
// Optional feature macro: IMM_RANGE_CHECK_EN (range checking, out_err, err_count).
// Without it out_err and err_count are constant 0 and immediates are truncated.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   in_valid / in_ready   request handshake
//   in_immsrc             format: 000 I, 001 S, 010 B, 011 J, 100 U
//   in_imm                32-bit signed immediate
//   in_opcode, in_rd, in_rs1, in_rs2, in_funct3  instruction fields
//   out_valid / out_ready encoded-word handshake
//   out_instr             encoded instruction (0 for illegal immsrc)
//   out_err               immediate out of range or immsrc illegal
//   err_count             saturating count of errored words delivered
module imm_encoder
    import riscv_imm_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_immsrc,
    input  logic [31:0] in_imm,
    input  logic [6:0]  in_opcode,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_err,
    output logic [7:0]  err_count
);

    logic        s1_valid;
    logic [2:0]  s1_immsrc;
    logic [31:0] s1_imm;
    logic [6:0]  s1_opcode;
    logic [4:0]  s1_rd;
    logic [4:0]  s1_rs1;
    logic [4:0]  s1_rs2;
    logic [2:0]  s1_funct3;

    logic s2_load;
    logic s1_load;

    // Both stages advance together when the consumer drains the output, so a
    // full pipe still moves one word per cycle without a bubble.
    assign s2_load  = !out_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_immsrc <= 3'b0;
            s1_imm    <= 32'h0;
            s1_opcode <= 7'b0;
            s1_rd     <= 5'b0;
            s1_rs1    <= 5'b0;
            s1_rs2    <= 5'b0;
            s1_funct3 <= 3'b0;
        end else if (s1_load) begin
            s1_valid  <= in_valid;
            s1_immsrc <= in_immsrc;
            s1_imm    <= in_imm;
            s1_opcode <= in_opcode;
            s1_rd     <= in_rd;
            s1_rs1    <= in_rs1;
            s1_rs2    <= in_rs2;
            s1_funct3 <= in_funct3;
        end
    end

    // The word register only changes when a new word arrives, which keeps it
    // stable under backpressure.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_instr <= 32'h0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_instr <= encode_instr(s1_immsrc, s1_imm, s1_opcode,
                                          s1_rd, s1_rs1, s1_rs2, s1_funct3);
            end
        end
    end

`ifdef IMM_RANGE_CHECK_EN
    logic range_err;
    logic s1_err;

    imm_range_check u_range_check (
        .immsrc (in_immsrc),
        .imm    (in_imm),
        .err    (range_err)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_err <= 1'b0;
        end else if (s1_load) begin
            s1_err <= range_err;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_err <= 1'b0;
        end else if (s2_load && s1_valid) begin
            out_err <= s1_err;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_count <= 8'd0;
        end else if (out_valid && out_ready && out_err && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`else
    assign out_err   = 1'b0;
    assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// tb/tb_imm_encoder.sv - scoreboard bench for imm_encoder
module tb_imm_encoder;
    import riscv_imm_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_immsrc = 3'b0;
    logic [31:0] in_imm = 32'h0;
    logic [6:0]  in_opcode = 7'b0;
    logic [4:0]  in_rd = 5'b0;
    logic [4:0]  in_rs1 = 5'b0;
    logic [4:0]  in_rs2 = 5'b0;
    logic [2:0]  in_funct3 = 3'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic        out_err;
    logic [7:0]  err_count;

    imm_encoder dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_immsrc (in_immsrc),
        .in_imm    (in_imm),
        .in_opcode (in_opcode),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

`ifdef IMM_RANGE_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] instr;
        logic        err;
        logic [2:0]  src;
        logic [31:0] imm;
        bit          rt;
    } sb_entry_t;

    sb_entry_t sb[$];
    int n_checks = 0;
    int n_pass   = 0;
    int accept_cnt = 0;
    int pop_cnt    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] model_encode(input logic [2:0] src, input logic [31:0] imm,
                                                 input logic [6:0] op, input logic [4:0] rd,
                                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                                 input logic [2:0] f3);
        logic [31:0] r;
        r = 32'h0;
        r[6:0] = op;
        case (src)
            3'd0: begin
                r[11:7] = rd; r[14:12] = f3; r[19:15] = rs1; r[31:20] = imm[11:0];
            end
            3'd1: begin
                r[11:7] = imm[4:0]; r[14:12] = f3; r[19:15] = rs1; r[24:20] = rs2;
                r[31:25] = imm[11:5];
            end
            3'd2: begin
                r[7] = imm[11]; r[11:8] = imm[4:1]; r[14:12] = f3; r[19:15] = rs1;
                r[24:20] = rs2; r[30:25] = imm[10:5]; r[31] = imm[12];
            end
            3'd3: begin
                r[11:7] = rd; r[19:12] = imm[19:12]; r[20] = imm[11];
                r[30:21] = imm[10:1]; r[31] = imm[20];
            end
            3'd4: begin
                r[11:7] = rd; r[31:12] = imm[31:12];
            end
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    function automatic bit model_inrange(input logic [2:0] src, input logic [31:0] imm);
        int s;
        s = $signed(imm);
        case (src)
            3'd0, 3'd1: return (s >= -2048) && (s <= 2047);
            3'd2:       return (s >= -4096) && (s <= 4095) && !imm[0];
            3'd3:       return (s >= -1048576) && (s <= 1048575) && !imm[0];
            3'd4:       return imm[11:0] == 12'h0;
            default:    return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] i, input logic [2:0] src);
        case (src)
            3'd0:    return {{20{i[31]}}, i[31:20]};
            3'd1:    return {{20{i[31]}}, i[31:25], i[11:7]};
            3'd2:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd3:    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: return {i[31:12], 12'h0};
        endcase
    endfunction

    // Monitor: predicts on input handshakes, compares on output handshakes.
    logic        stall_prev = 1'b0;
    logic [31:0] prev_instr;
    logic        prev_err;

    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_instr", out_instr, prev_instr);
                check("hold_err", {31'b0, out_err}, {31'b0, prev_err});
            end
            if (out_valid && out_ready) begin
                pop_cnt++;
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'd0, 32'd1);
                end else begin
                    sb_entry_t e;
                    e = sb.pop_front();
                    check("sb_instr", out_instr, e.instr);
                    check("sb_err", {31'b0, out_err}, {31'b0, e.err});
                    if (e.rt) begin
                        if (e.src == IMM_U)
                            check("rt_u", {out_instr[31:12], 12'h0}, {e.imm[31:12], 12'h0});
                        else
                            check("rt_ext", extend(out_instr, e.src), e.imm);
                    end
                end
            end
            if (in_valid && in_ready) begin
                sb_entry_t n;
                bit ok;
                accept_cnt++;
                ok      = model_inrange(in_immsrc, in_imm);
                n.instr = model_encode(in_immsrc, in_imm, in_opcode, in_rd, in_rs1, in_rs2, in_funct3);
                n.err   = CHECK_EN ? !ok : 1'b0;
                n.src   = in_immsrc;
                n.imm   = in_imm;
                n.rt    = ok;
                sb.push_back(n);
            end
            stall_prev = out_valid && !out_ready;
            prev_instr = out_instr;
            prev_err   = out_err;
        end
    end

    task automatic send(input logic [2:0] src, input logic [31:0] imm, input logic [6:0] op,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [2:0] f3);
        bit ok;
        in_immsrc = src; in_imm = imm; in_opcode = op;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_funct3 = f3;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", {31'b0, ok}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check("drain_timeout", {31'b0, done}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
    endtask

    bit rand_on;

    initial begin
        int lat;
        int acc0;
        int pop0;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_out_err", {31'b0, out_err}, 32'd0);
        check("rst_err_count", {24'b0, err_count}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Directed encodings with independently known words.
        send(IMM_I, 32'hFFFF_FFFF, OP_IMM, 5'd1, 5'd2, 5'd0, 3'b000);
        wait_out(lat);
        check("lat_i", lat, 32'd2);
        check("dir_i", out_instr, 32'hFFF1_0093);
        check("dir_i_err", {31'b0, out_err}, 32'd0);
        drain();

        send(IMM_S, 32'd8, OP_STORE, 5'd0, 5'd2, 5'd5, 3'b010);
        wait_out(lat);
        check("dir_s", out_instr, 32'h0051_2423);
        drain();

        send(IMM_B, -32'sd4, OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'b000);
        wait_out(lat);
        check("dir_b", out_instr, 32'hFE00_0EE3);
        drain();

        send(IMM_J, 32'd2048, OP_JAL, 5'd1, 5'd0, 5'd0, 3'b000);
        wait_out(lat);
        check("dir_j", out_instr, 32'h0010_00EF);
        drain();

        send(IMM_J, 32'd3, OP_JAL, 5'd1, 5'd0, 5'd0, 3'b000);
        wait_out(lat);
        check("dir_j_err", {31'b0, out_err}, {31'b0, CHECK_EN});
        drain();
        check("err_count_1", {24'b0, err_count}, CHECK_EN ? 32'd1 : 32'd0);

        send(3'b101, 32'd5, OP_IMM, 5'd3, 5'd4, 5'd5, 3'b111);
        wait_out(lat);
        check("illegal_instr", out_instr, 32'h0);
        check("illegal_err", {31'b0, out_err}, {31'b0, CHECK_EN});
        drain();

        // Backpressure: consumer stalls while four requests arrive back to back.
        out_ready = 1'b0;
        acc0 = accept_cnt;
        pop0 = pop_cnt;
        fork
            begin
                send(IMM_I, 32'd1, OP_IMM, 5'd1, 5'd1, 5'd0, 3'b000);
                send(IMM_I, 32'd2, OP_IMM, 5'd2, 5'd2, 5'd0, 3'b001);
                send(IMM_S, 32'd3, OP_STORE, 5'd0, 5'd3, 5'd3, 3'b010);
                send(IMM_U, 32'h1234_5000, OP_LUI, 5'd4, 5'd0, 5'd0, 3'b000);
            end
            begin
                repeat (3) @(posedge clk);
                @(negedge clk);
                check("bp_accepts", accept_cnt - acc0, 32'd2);
                check("bp_in_ready", {31'b0, in_ready}, 32'd0);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("bp_delivered", pop_cnt - pop0, 32'd4);

        // Saturation of the error counter.
        for (int i = 0; i < 260; i++)
            send(IMM_I, 32'd4096, OP_IMM, 5'd1, 5'd1, 5'd0, 3'b000);
        drain();
        check("err_sat", {24'b0, err_count}, CHECK_EN ? 32'd255 : 32'd0);

        // Reset in the middle of a stream.
        in_immsrc = IMM_I; in_imm = 32'd4096; in_opcode = OP_IMM;
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_err_count", {24'b0, err_count}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Random in-range round trip with a randomly stalling consumer.
        rand_on = 1'b1;
        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    logic [2:0]  src;
                    logic [31:0] r;
                    logic [31:0] imm;
                    src = 3'($urandom_range(0, 4));
                    r   = $urandom;
                    case (src)
                        3'd0, 3'd1: imm = {{20{r[11]}}, r[11:0]};
                        3'd2:       imm = {{19{r[12]}}, r[12:1], 1'b0};
                        3'd3:       imm = {{11{r[20]}}, r[20:1], 1'b0};
                        default:    imm = {r[31:12], 12'h0};
                    endcase
                    send(src, imm, 7'($urandom), 5'($urandom), 5'($urandom),
                         5'($urandom), 3'($urandom));
                end
                rand_on = 1'b0;
            end
            begin
                while (rand_on) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
